// File: rtl/dwell_timer_pkg.sv
// Shared types and constants for the dwell/timeout counter bank.
package dwell_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b11
    } state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    // Channel-select width; a single channel still needs a 1-bit field.
    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dwell_timer_bank_if.sv
// Control/status bundle between the paint engine and the dwell timer bank.
interface dwell_timer_bank_if
    import dwell_timer_pkg::*;
#(
    parameter int unsigned NCH   = 4,
    parameter int unsigned CNT_W = 24
) ();

    localparam int unsigned CH_W = ch_width(NCH);

    logic [NCH-1:0]   start;
    logic [NCH-1:0]   abort;
    logic [NCH-1:0]   mode;
    logic             tc_we;
    logic [CH_W-1:0]  tc_ch;
    logic [CNT_W-1:0] tc_data;
    logic [NCH-1:0]   busy;
    logic [NCH-1:0]   done;
    logic [NCH-1:0]   tick;
    logic [NCH-1:0]   clr_out;

    modport master (
        output start, abort, mode, tc_we, tc_ch, tc_data,
        input  busy, done, tick, clr_out
    );

    modport slave (
        input  start, abort, mode, tc_we, tc_ch, tc_data,
        output busy, done, tick, clr_out
    );

endinterface

// File: rtl/dwell_timer_ch.sv
// One dwell timer channel: IDLE/RUN/DONE control, counter, programmable
// terminal count and the shadow copy used by the count in progress.
module dwell_timer_ch
    import dwell_timer_pkg::*;
#(
    parameter int unsigned CNT_W      = 24,
    parameter int unsigned DEFAULT_TC = 5000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             mode,
    input  logic             tc_we,
    input  logic [CNT_W-1:0] tc_data,
    output logic             busy,
    output logic             done,
    output logic             tick,
    output logic             clr_out
);

    localparam logic [CNT_W-1:0] TC_RST = CNT_W'(DEFAULT_TC);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] tc_reg, tc_reg_n;
    logic [CNT_W-1:0] active_tc, active_tc_n;
    logic [CNT_W-1:0] tc_sel;
    logic             mode_q, mode_n;
    logic             tick_q, tick_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            tc_reg    <= TC_RST;
            active_tc <= TC_RST;
            mode_q    <= MODE_ONESHOT;
            tick_q    <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            tc_reg    <= tc_reg_n;
            active_tc <= active_tc_n;
            mode_q    <= mode_n;
            tick_q    <= tick_n;
        end
    end

    // A write coinciding with start is seen by that start (write-through).
    assign tc_sel = tc_we ? tc_data : tc_reg;

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        tc_reg_n    = tc_we ? tc_data : tc_reg;
        active_tc_n = active_tc;
        mode_n      = mode_q;
        tick_n      = 1'b0;
        if (abort) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
        end else if (start) begin
            state_n     = ST_RUN;
            cnt_n       = '0;
            active_tc_n = (tc_sel == '0) ? CNT_W'(1) : tc_sel;
            mode_n      = mode;
        end else if (state == ST_RUN) begin
            if (cnt == active_tc - CNT_W'(1)) begin
                tick_n = 1'b1;
                if (mode_q == MODE_PERIODIC) begin
                    cnt_n = '0;
                end else begin
                    state_n = ST_DONE;
                end
            end else begin
                cnt_n = cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        busy    = (state == ST_RUN);
        done    = (state == ST_DONE);
        clr_out = (state == ST_IDLE);
        tick    = tick_q;
    end

endmodule

// File: rtl/dwell_timer_bank.sv
// Bank of independent dwell/timeout channels; decodes the terminal-count
// write address and slices the per-channel bus bits.
module dwell_timer_bank
    import dwell_timer_pkg::*;
#(
    parameter int unsigned NCH        = 4,
    parameter int unsigned CNT_W      = 24,
    parameter int unsigned DEFAULT_TC = 5000000
) (
    input logic               clk,
    input logic               rst,
    dwell_timer_bank_if.slave bus
);

    localparam int unsigned CH_W = ch_width(NCH);

    logic [NCH-1:0] busy_v;
    logic [NCH-1:0] done_v;
    logic [NCH-1:0] tick_v;
    logic [NCH-1:0] clr_v;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic we;

        // Addresses at or beyond NCH match no channel and are dropped.
        assign we = bus.tc_we && (bus.tc_ch == CH_W'(i));

        dwell_timer_ch #(
            .CNT_W      (CNT_W),
            .DEFAULT_TC (DEFAULT_TC)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .start   (bus.start[i]),
            .abort   (bus.abort[i]),
            .mode    (bus.mode[i]),
            .tc_we   (we),
            .tc_data (bus.tc_data),
            .busy    (busy_v[i]),
            .done    (done_v[i]),
            .tick    (tick_v[i]),
            .clr_out (clr_v[i])
        );
    end

    assign bus.busy    = busy_v;
    assign bus.done    = done_v;
    assign bus.tick    = tick_v;
    assign bus.clr_out = clr_v;

endmodule

// File: tb/tb_dwell_timer_bank.sv
// Directed bench for dwell_timer_bank (NCH=4, CNT_W=8, DEFAULT_TC=5).
module tb_dwell_timer_bank;

    localparam int unsigned NCH   = 4;
    localparam int unsigned CNT_W = 8;

    logic clk = 1'b0;
    logic rst;

    int unsigned total    = 0;
    int unsigned pass_cnt = 0;
    int unsigned fail_cnt = 0;

    always #5 clk = ~clk;

    dwell_timer_bank_if #(.NCH(NCH), .CNT_W(CNT_W)) bus ();

    dwell_timer_bank #(
        .NCH        (NCH),
        .CNT_W      (CNT_W),
        .DEFAULT_TC (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst         = 1'b1;
        bus.start   = '0;
        bus.abort   = '0;
        bus.mode    = '0;
        bus.tc_we   = 1'b0;
        bus.tc_ch   = '0;
        bus.tc_data = '0;
        cyc();
        cyc();
        check("rst busy", 32'(bus.busy), 32'h0);
        check("rst done", 32'(bus.done), 32'h0);
        check("rst tick", 32'(bus.tick), 32'h0);
        check("rst clr_out", 32'(bus.clr_out), 32'hF);
        rst = 1'b0;

        // One-shot on channel 0 with the reset terminal count of 5
        bus.mode  = 4'b0000;
        bus.start = 4'b0001;
        cyc();
        bus.start = '0;
        check("t1 busy", 32'(bus.busy[0]), 32'd1);
        check("t1 clr_out", 32'(bus.clr_out[0]), 32'd0);
        for (int c = 0; c <= 6; c++) begin
            check($sformatf("t1 tick c=%0d", c), 32'(bus.tick[0]), 32'(c == 5));
            cyc();
        end
        for (int c = 0; c < 20; c++) begin
            check($sformatf("t1 done hold %0d", c), 32'(bus.done[0]), 32'd1);
            check($sformatf("t1 clr hold %0d", c), 32'(bus.clr_out[0]), 32'd0);
        cyc();
        end

        // Periodic with TC=3 on channel 2
        bus.tc_we   = 1'b1;
        bus.tc_ch   = 2'd2;
        bus.tc_data = 8'd3;
        cyc();
        bus.tc_we = 1'b0;
        bus.mode  = 4'b0100;
        bus.start = 4'b0100;
        cyc();
        bus.start = '0;
        for (int c = 0; c <= 30; c++) begin
            check($sformatf("t2 tick c=%0d", c), 32'(bus.tick[2]), 32'(c > 0 && c % 3 == 0));
            check($sformatf("t2 done c=%0d", c), 32'(bus.done[2]), 32'd0);
            cyc();
        end
        bus.abort = 4'b0100;
        cyc();
        bus.abort = '0;
        check("t2 abort clr", 32'(bus.clr_out[2]), 32'd1);

        // Restart channel 1 three cycles into its count
        bus.mode  = 4'b0000;
        bus.start = 4'b0010;
        cyc();
        bus.start = '0;
        check("t3 tick c=0", 32'(bus.tick[1]), 32'd0);
        cyc();
        check("t3 tick c=1", 32'(bus.tick[1]), 32'd0);
        cyc();
        check("t3 tick c=2", 32'(bus.tick[1]), 32'd0);
        bus.start = 4'b0010;
        cyc();
        bus.start = '0;
        for (int c = 0; c <= 5; c++) begin
            check($sformatf("t3 restart tick c=%0d", c), 32'(bus.tick[1]), 32'(c == 5));
            cyc();
        end
        check("t3 done", 32'(bus.done[1]), 32'd1);

        // Abort channel 3 mid-count, then abort+start together
        bus.start = 4'b1000;
        cyc();
        bus.start = '0;
        check("t4 busy", 32'(bus.busy[3]), 32'd1);
        cyc();
        bus.abort = 4'b1000;
        cyc();
        bus.abort = '0;
        check("t4 busy after abort", 32'(bus.busy[3]), 32'd0);
        check("t4 done after abort", 32'(bus.done[3]), 32'd0);
        for (int c = 2; c <= 7; c++) begin
            check($sformatf("t4 no tick c=%0d", c), 32'(bus.tick[3]), 32'd0);
            check($sformatf("t4 clr c=%0d", c), 32'(bus.clr_out[3]), 32'd1);
            cyc();
        end
        bus.abort = 4'b1000;
        bus.start = 4'b1000;
        cyc();
        bus.abort = '0;
        bus.start = '0;
        check("t4 abort+start clr", 32'(bus.clr_out[3]), 32'd1);
        check("t4 abort+start busy", 32'(bus.busy[3]), 32'd0);
        cyc();
        check("t4 still idle", 32'(bus.clr_out[3]), 32'd1);

        // TC write just after start is shadowed until the next start
        bus.mode  = 4'b0000;
        bus.start = 4'b0001;
        cyc();
        bus.start   = '0;
        bus.tc_we   = 1'b1;
        bus.tc_ch   = 2'd0;
        bus.tc_data = 8'd9;
        check("t5 tick c=0", 32'(bus.tick[0]), 32'd0);
        cyc();
        bus.tc_we = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            check($sformatf("t5 tick c=%0d", c), 32'(bus.tick[0]), 32'(c == 5));
            cyc();
        end
        check("t5 done", 32'(bus.done[0]), 32'd1);
        bus.start = 4'b0001;
        cyc();
        bus.start = '0;
        for (int c = 0; c <= 9; c++) begin
            check($sformatf("t5 tc9 tick c=%0d", c), 32'(bus.tick[0]), 32'(c == 9));
            cyc();
        end
        check("t5 tc9 done", 32'(bus.done[0]), 32'd1);

        // TC=0 periodic on channel 1 behaves as TC=1
        bus.tc_we   = 1'b1;
        bus.tc_ch   = 2'd1;
        bus.tc_data = 8'd0;
        cyc();
        bus.tc_we = 1'b0;
        bus.mode  = 4'b0010;
        bus.start = 4'b0010;
        cyc();
        bus.start = '0;
        for (int c = 0; c <= 6; c++) begin
            check($sformatf("t6 tick c=%0d", c), 32'(bus.tick[1]), 32'(c >= 1));
            check($sformatf("t6 busy c=%0d", c), 32'(bus.busy[1]), 32'd1);
            cyc();
        end

        // Reset mid-count, with starts asserted alongside it
        bus.mode  = 4'b0110;
        bus.start = 4'b1100;
        cyc();
        bus.start = '0;
        cyc();
        cyc();
        rst       = 1'b1;
        bus.start = 4'b1111;
        cyc();
        rst       = 1'b0;
        bus.start = '0;
        check("t7 busy", 32'(bus.busy), 32'h0);
        check("t7 done", 32'(bus.done), 32'h0);
        check("t7 tick", 32'(bus.tick), 32'h0);
        check("t7 clr_out", 32'(bus.clr_out), 32'hF);
        cyc();
        check("t7 tick idle", 32'(bus.tick), 32'h0);
        check("t7 clr idle", 32'(bus.clr_out), 32'hF);
        bus.mode  = 4'b0000;
        bus.start = 4'b1111;
        cyc();
        bus.start = '0;
        for (int c = 0; c <= 5; c++) begin
            check($sformatf("t7 tc5 tick c=%0d", c), 32'(bus.tick), (c == 5) ? 32'hF : 32'h0);
            cyc();
        end
        check("t7 tc5 done", 32'(bus.done), 32'hF);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/dwell_timer_bank.md
Name: dwell_timer_bank

Overview:
- Bank of NCH independent dwell/timeout counters. Each channel counts clock cycles up to a programmable terminal count, then flags completion.
- Serves the paint engine's wait points: white-fill dwell, cursor-blink period, and button hold-to-repeat.
- Generalises the single fixed-threshold count controller used today. Adds per-channel terminal count, one-shot/periodic mode, abort and restart.

Parameters:
- NCH, 4, number of independent timer channels (1..16).
- CNT_W, 24, counter and terminal-count width in bits.
- DEFAULT_TC, 5000000, terminal count loaded into every channel at reset; must fit in CNT_W bits.
- CH_W, clog2(NCH) (minimum 1), width of the channel-select field; derived, not overridden.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  NCH  per-channel start/restart request, sampled each cycle.
- abort  in  NCH  per-channel abort; returns the channel to IDLE.
- mode  in  NCH  per-channel mode, latched at start: 0 = one-shot, 1 = periodic.
- tc_we  in  1  terminal-count register write enable.
- tc_ch  in  CH_W  channel addressed by the write.
- tc_data  in  CNT_W  terminal-count value to write.
- busy  out  NCH  channel is in RUN.
- done  out  NCH  level; one-shot channel has completed (DONE state).
- tick  out  NCH  one-cycle pulse on each expiry, in both modes.
- clr_out  out  NCH  high while the channel is in IDLE; clears downstream accumulators.

Behaviour:
- Per-channel state machine with three states:
  - IDLE: busy=0, done=0, clr_out=1.
  - RUN: busy=1, done=0, clr_out=0.
  - DONE: busy=0, done=1, clr_out=0.
- Reset values: all channels IDLE, counters 0, tc_reg = DEFAULT_TC, active_tc = DEFAULT_TC, tick=0, done=0, busy=0, clr_out=all ones.
- Reset takes effect on the next rising edge and overrides all other inputs, including mid-count.
- Registered outputs are decoded from state. tick is a registered pulse asserted in the cycle following the expiry edge.
- Priority per channel per cycle: rst > abort > start > count.
- abort: from any state, go to IDLE, counter=0, no tick.
- start from IDLE, RUN or DONE:
  - go to RUN, counter=0;
  - active_tc <= (tc_reg==0 ? 1 : tc_reg);
  - latch mode.
  - A start while in RUN restarts the count and produces no tick.
- Counting in RUN: counter increments by 1 per cycle. When counter == active_tc-1 at a rising edge, the channel expires:
  - one-shot: go to DONE, counter held, tick=1 for the next cycle;
  - periodic: stay in RUN, counter wraps to 0, tick=1 for the next cycle.
- Expiry timing: with TC=N, tick appears N cycles after the start edge. A periodic channel ticks every N cycles. TC=1 in periodic mode ticks every cycle.
- DONE is held until start, abort or rst. start and mode are ignored only when abort is high in the same cycle.
- tc_reg write: when tc_we=1, tc_reg[tc_ch] <= tc_data. A write to a running channel affects only the next start, because active_tc is shadowed.
  - A write and a start on the same channel in the same cycle: active_tc takes the new tc_data (write-through).
  - A tc_ch value >= NCH is ignored.
- Counter arithmetic is unsigned CNT_W bits. The counter never exceeds active_tc-1, so no overflow is possible.
- Channels are fully independent; simultaneous events on different channels do not interact.

Decomposition:
- Package dwell_timer_pkg:
  - state encodings ST_IDLE=2'b00, ST_RUN=2'b01, ST_DONE=2'b11;
  - mode constants MODE_ONESHOT=1'b0, MODE_PERIODIC=1'b1.
- Sub-module dwell_timer_ch: one channel, containing the state machine, counter, tc_reg and active_tc shadow. Instantiated NCH times in a generate loop.
- The top level does only tc_ch decode and port slicing.

Test Plan (NCH=4, CNT_W=8, DEFAULT_TC=5):
- Reset release, then a one-cycle start[0] with mode=0:
  - busy[0]=1 the next cycle;
  - tick[0] a single pulse 5 cycles after the start edge;
  - done[0]=1 and clr_out[0]=0 held for 20 further cycles.
- Write TC=3 to channel 2, then start[2] with mode=1: tick[2] pulses exactly every 3 cycles for 10 periods; done[2] stays 0 throughout.
- Start channel 1, start again after 3 cycles: no tick at the original expiry; tick 5 cycles after the second start.
- Start channel 3, abort at cycle 2:
  - IDLE the next cycle, clr_out[3]=1, no tick;
  - abort and start asserted together in a later cycle leave the channel in IDLE.
- Start channel 0 with TC=5, write TC=9 on the cycle after start: expiry still at 5 cycles. A restart then expires at 9 cycles.
- Write TC=0 to channel 1, start with mode=1: tick every cycle.
- Assert rst mid-count on all channels: all outputs return to reset values, and tc_reg returns to 5.
